// File: rtl/axis_fifo_arbiter_if.sv
// FIFO-side and AXI-Stream-side signals of axis_fifo_arbiter; master = arbiter, slave = FIFOs + sink.
interface axis_fifo_arbiter_if #(
    parameter int N      = 4,
    parameter int DWIDTH = 16
);
    localparam int DEST_W = $clog2(N);

    logic [N-1:0]        fifo_empty;
    logic [N*DWIDTH-1:0] fifo_dout;
    logic [N-1:0]        fifo_rd_en;
    logic [DWIDTH-1:0]   m_axis_tdata;
    logic                m_axis_tvalid;
    logic                m_axis_tready;
    logic                m_axis_tlast;
    logic [DEST_W-1:0]   m_axis_tdest;

    modport master (
        input  fifo_empty, fifo_dout, m_axis_tready,
        output fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );

    modport slave (
        output fifo_empty, fifo_dout, m_axis_tready,
        input  fifo_rd_en, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tdest
    );
endinterface

// File: rtl/axis_fifo_arbiter.sv
// Drains N read-latency-1 FIFOs onto one AXIS port, up to BURST beats per packet; AXIS_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
// Latency 2 cycles rd_en to tvalid; tready low stalls a 2-entry output buffer and read issue is credit-limited so it never overflows.
module axis_fifo_arbiter #(
    parameter int N      = 4,
    parameter int DWIDTH = 16,
    parameter int BURST  = 8
) (
    input logic clk,
    input logic rst,
    axis_fifo_arbiter_if.master io_bus
);
    localparam int DEST_W = $clog2(N);
    localparam int CW     = $clog2(BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] dat;
        logic              last;
        logic [DEST_W-1:0] dest;
    } beat_t;

    state_t            r_state, w_state_nxt;
    logic [DEST_W-1:0] r_grant, r_last_grant, w_arb_idx;
    logic              w_arb_hit;
    logic [CW-1:0]     r_issued, r_beat_cnt;
    logic              r_inflight;
    beat_t             r_buf [2];
    logic              r_wptr, r_rptr;
    logic [1:0]        r_occ;
    logic              w_pop, w_issue, w_cap_last, w_credit, w_grant_empty;
    beat_t             w_cap;

    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_idx = '0;
`ifdef AXIS_ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (!io_bus.fifo_empty[i]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = DEST_W'(i);
            end
        end
`else
        // Descending scan so the nearest index after last_grant wins.
        for (int k = N; k >= 1; k--) begin
            if (!io_bus.fifo_empty[(int'(r_last_grant) + k) % N]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = DEST_W'((int'(r_last_grant) + k) % N);
            end
        end
`endif
    end

    assign w_grant_empty = io_bus.fifo_empty[r_grant];
    assign w_pop         = io_bus.m_axis_tvalid && io_bus.m_axis_tready;
    assign w_credit      = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_cap_last    = (r_beat_cnt == CW'(BURST - 1)) || w_grant_empty;
    assign w_issue       = !rst && (r_state == S_XFER) && !w_grant_empty && w_credit &&
                           (r_issued < CW'(BURST)) && !(r_inflight && w_cap_last);

    always_comb begin
        w_cap.dat  = io_bus.fifo_dout[int'(r_grant)*DWIDTH +: DWIDTH];
        w_cap.last = w_cap_last;
        w_cap.dest = r_grant;
    end

    always_comb begin
        io_bus.fifo_rd_en = '0;
        if (w_issue) io_bus.fifo_rd_en[r_grant] = 1'b1;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_arb_hit) w_state_nxt = S_XFER;
            S_XFER:  if (r_inflight && w_cap_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_last_grant <= DEST_W'(N - 1);
            r_issued     <= '0;
            r_beat_cnt   <= '0;
            r_inflight   <= 1'b0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_occ        <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (r_state == S_IDLE && w_arb_hit) begin
                r_grant    <= w_arb_idx;
                r_beat_cnt <= '0;
                r_issued   <= '0;
            end
            if (w_issue) r_issued <= r_issued + CW'(1);
            if (r_inflight) begin
                r_buf[r_wptr] <= w_cap;
                r_wptr        <= ~r_wptr;
                r_beat_cnt    <= r_beat_cnt + CW'(1);
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            if (r_state == S_DONE) r_last_grant <= r_grant;
        end
    end

    assign io_bus.m_axis_tvalid = (r_occ != 2'd0);
    assign io_bus.m_axis_tdata  = r_buf[r_rptr].dat;
    assign io_bus.m_axis_tlast  = r_buf[r_rptr].last;
    assign io_bus.m_axis_tdest  = r_buf[r_rptr].dest;
endmodule

// File: tb/tb_axis_fifo_arbiter.sv
// Bench for axis_fifo_arbiter: behavioural read-latency-1 FIFOs, beat scoreboard, table of single-source drains plus corner sequences.
module tb_axis_fifo_arbiter;
    localparam int N      = 4;
    localparam int DW     = 16;
    localparam int BURST  = 8;
    localparam int DEST_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_fifo_arbiter_if #(.N(N), .DWIDTH(DW)) io ();
    axis_fifo_arbiter #(.N(N), .DWIDTH(DW), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .io_bus(io.master)
    );

    typedef struct packed {
        logic [DW-1:0]     dat;
        logic              last;
        logic [DEST_W-1:0] dest;
    } beat_t;
    typedef struct {
        int            idx;
        logic [DW-1:0] dat;
    } wr_t;
    typedef struct {
        int            src;
        int            n;
        logic [DW-1:0] base;
        int            exp_pkts;
        int            exp_beats;
    } vec_t;

    beat_t         exp_q[$];
    wr_t           pend[$];
    logic [DW-1:0] fq[N][$];
    int tests = 0;
    int fails = 0;
    int rd_cnt[N];
    int beats_d[N];
    int beats = 0;
    int lasts = 0;
    int tready_mode = 0;
    int cyc = 0;

    // FIFO models: dout and empty update on the edge that samples rd_en; writes land on the same edge.
    always @(posedge clk) begin
        logic [N*DW-1:0] d;
        logic [N-1:0]    e;
        wr_t             w;
        d = io.fifo_dout;
        for (int i = 0; i < N; i++)
            if (io.fifo_rd_en[i] && fq[i].size() > 0) d[i*DW +: DW] = fq[i].pop_front();
        while (pend.size() > 0) begin
            w = pend.pop_front();
            fq[w.idx].push_back(w.dat);
        end
        for (int i = 0; i < N; i++) e[i] = (fq[i].size() == 0);
        io.fifo_dout  <= d;
        io.fifo_empty <= e;
    end

    always @(posedge clk) begin
        #2;
        cyc++;
        case (tready_mode)
            1:       io.m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       io.m_axis_tready = 1'b0;
            default: io.m_axis_tready = 1'b1;
        endcase
    end

    beat_t got, e, held;
    logic  stall_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            got = {io.m_axis_tdata, io.m_axis_tlast, io.m_axis_tdest};
            tests++;
            if (!$onehot0(io.fifo_rd_en)) begin
                fails++;
                $display("FAIL rd_en_onehot: got %b required at most one bit", io.fifo_rd_en);
            end
            for (int i = 0; i < N; i++) rd_cnt[i] += int'(io.fifo_rd_en[i]);
            if (stall_prev) begin
                tests++;
                if (!io.m_axis_tvalid || got != held) begin
                    fails++;
                    $display("FAIL stall_hold: got vld=%b beat=%h required vld=1 beat=%h",
                             io.m_axis_tvalid, got, held);
                end
            end
            if (io.m_axis_tvalid && io.m_axis_tready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_beat: got data=%h last=%b dest=%0d required no beat",
                             got.dat, got.last, got.dest);
                end else begin
                    e = exp_q.pop_front();
                    if (got != e) begin
                        fails++;
                        $display("FAIL beat: got data=%h last=%b dest=%0d required data=%h last=%b dest=%0d",
                                 got.dat, got.last, got.dest, e.dat, e.last, e.dest);
                    end
                end
                beats++;
                if (got.last) lasts++;
                beats_d[got.dest]++;
            end
            stall_prev = io.m_axis_tvalid && !io.m_axis_tready;
            held       = got;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic load(int idx, logic [DW-1:0] base, int n);
        for (int k = 0; k < n; k++) pend.push_back('{idx, DW'(base + k)});
    endtask

    task automatic expect_pkt(int dest, logic [DW-1:0] base, int n);
        for (int k = 0; k < n; k++) exp_q.push_back(beat_t'{DW'(base + k), (k == n - 1), DEST_W'(dest)});
    endtask

    task automatic expect_drain(int src, logic [DW-1:0] base, int n);
        int off = 0;
        while (off < n) begin
            int l = (n - off > BURST) ? BURST : n - off;
            expect_pkt(src, DW'(base + off), l);
            off += l;
        end
    endtask

    task automatic wait_drain(string name);
        int c = 0;
        while (!(exp_q.size() == 0 && pend.size() == 0 && io.fifo_empty == {N{1'b1}} &&
                 !io.m_axis_tvalid) && c < 3000) begin
            step();
            c++;
        end
        chk({name, "_drain_timeout"}, (c < 3000), 1);
        if (c >= 3000) exp_q.delete();
        repeat (4) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        exp_q.delete();
        step();
    endtask

    vec_t tbl[6];
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int l0, b0, r0, c, rem;
        tbl[0] = '{0,  3, 16'h00A0, 1,  3};
        tbl[1] = '{1, 20, 16'h0100, 3, 20};
        tbl[2] = '{2,  8, 16'h0200, 1,  8};
        tbl[3] = '{3,  9, 16'h0300, 2,  9};
        tbl[4] = '{0,  1, 16'h0400, 1,  1};
        tbl[5] = '{2, 16, 16'h0500, 2, 16};
        for (int i = 0; i < N; i++) begin
            rd_cnt[i]  = 0;
            beats_d[i] = 0;
        end

        repeat (3) step();
        chk("rst_tvalid", io.m_axis_tvalid, 0);
        chk("rst_tlast",  io.m_axis_tlast,  0);
        chk("rst_tdata",  io.m_axis_tdata,  0);
        chk("rst_tdest",  io.m_axis_tdest,  0);
        chk("rst_rd_en",  io.fifo_rd_en,    0);
        rst = 1'b0;
        step();

        for (int t = 0; t < 6; t++) begin
            l0 = lasts;
            b0 = beats;
            r0 = rd_cnt[tbl[t].src];
            load(tbl[t].src, tbl[t].base, tbl[t].n);
            expect_drain(tbl[t].src, tbl[t].base, tbl[t].n);
            wait_drain($sformatf("vec%0d", t));
            chk($sformatf("vec%0d_pkts", t),  lasts - l0, tbl[t].exp_pkts);
            chk($sformatf("vec%0d_beats", t), beats - b0, tbl[t].exp_beats);
            chk($sformatf("vec%0d_reads", t), rd_cnt[tbl[t].src] - r0, tbl[t].n);
        end

        // Round-robin order, then wrap from last_grant=3 back to FIFO 0.
        do_reset();
        load(0, 16'h1000, 2); load(2, 16'h1200, 2); load(3, 16'h1300, 2);
        expect_pkt(0, 16'h1000, 2); expect_pkt(2, 16'h1200, 2); expect_pkt(3, 16'h1300, 2);
        wait_drain("rr_order");
        load(3, 16'h1310, 2); load(0, 16'h1010, 2);
        expect_pkt(0, 16'h1010, 2); expect_pkt(3, 16'h1310, 2);
        wait_drain("rr_wrap");

        tready_mode = 1;
        load(2, 16'h2000, 8);
        expect_pkt(2, 16'h2000, 8);
        wait_drain("stall");
        tready_mode = 0;

        do_reset();
        load(0, 16'h0A00, 20); load(1, 16'h0B00, 2);
`ifdef AXIS_ARB_FIXED_PRIO_EN
        expect_pkt(0, 16'h0A00, 8); expect_pkt(0, 16'h0A08, 8); expect_pkt(0, 16'h0A10, 4);
        expect_pkt(1, 16'h0B00, 2);
`else
        expect_pkt(0, 16'h0A00, 8); expect_pkt(1, 16'h0B00, 2);
        expect_pkt(0, 16'h0A08, 8); expect_pkt(0, 16'h0A10, 4);
`endif
        wait_drain("prio");

        // Reset after the 4th beat of an 8-beat packet from FIFO 1.
        do_reset();
        b0 = beats_d[1];
        load(1, 16'h0700, 8); load(2, 16'h0800, 2);
        expect_pkt(1, 16'h0700, 8); expect_pkt(2, 16'h0800, 2);
        c = 0;
        while ((beats_d[1] - b0) < 4 && c < 200) begin
            step();
            c++;
        end
        chk("mid_rst_reach_beat4", (c < 200), 1);
        rst = 1'b1;
        tready_mode = 2;
        load(0, 16'h0900, 2);
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("mid_rst_tvalid", io.m_axis_tvalid, 0);
        chk("mid_rst_rd_en",  io.fifo_rd_en,    0);
        rem = fq[1].size();
        expect_pkt(0, 16'h0900, 2);
        if (rem > 0) expect_pkt(1, DW'(16'h0708 - rem), rem);
        expect_pkt(2, 16'h0800, 2);
        step();
        tready_mode = 0;
        wait_drain("mid_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_fifo_arbiter.md
Name: axis_fifo_arbiter

Overview:
- Shares one AXI-Stream master port between N source FIFOs that use the team's 1-cycle-read-latency FIFO interface (wr_en/rd_en/din/dout/empty/full).
- Grants one FIFO at a time, round-robin, and drains up to BURST words from it as one AXIS packet (tlast on the final beat, tdest = source index).
- Only this block drives the FIFOs' rd_en; the FIFO write sides stay with the producers.

Parameters:
- N, 4, number of source FIFOs (2..16).
- DWIDTH, 16, data width; must equal the FIFOs' DWIDTH.
- BURST, 8, maximum beats per packet (1..256).
- DEST_W (localparam), $clog2(N), tdest width.

Ports:
- clk  in  1  single clock for block and FIFOs.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  N  empty flag of each FIFO; bit i = FIFO i.
- fifo_dout  in  N*DWIDTH  FIFO read data, flattened; slice i = [i*DWIDTH +: DWIDTH].
- fifo_rd_en  out  N  read strobe, at most one bit set (one-hot or zero).
- m_axis_tdata  out  DWIDTH  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tdest  out  DEST_W  index of the source FIFO for this beat.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, fifo_rd_en=0, m_axis_tvalid=0, tlast=0, tdata=0, tdest=0, buffer occupancy=0, inflight=0, beat_cnt=0, last_grant=N-1 (so FIFO 0 has first priority). Reset mid-packet abandons the packet. Any read already issued is discarded, and the block does not issue tlast for it.
- FIFO timing: the FIFO updates dout on the edge that samples rd_en & !empty. The block captures fifo_dout[grant] in the cycle after issue (inflight=1).
- Output buffer: 2-entry FIFO holding {data, last, dest}. The head drives the m_axis_* outputs. A pop occurs on tvalid & tready. tvalid is high iff occupancy>0. tdata/tlast/tdest stay stable while tvalid & !tready.
- Credit rule: a read may issue only when occupancy + inflight - pop < 2. With tready held high this gives 1 beat/cycle sustained throughput. The buffer never overflows.
- State IDLE:
  - If fifo_empty is all ones, stay in IDLE.
  - Otherwise grant = first non-empty index searching upward from last_grant+1, wrapping modulo N.
  - Set beat_cnt=0 and go to XFER next cycle. No read issues in the IDLE cycle.
- State XFER, issue side:
  - fifo_rd_en[grant]=1 when !fifo_empty[grant] && credit available && issued < BURST && no tlast captured yet.
- State XFER, capture side (inflight=1):
  - Push {fifo_dout[grant], last, grant}.
  - last = (beat_cnt==BURST-1) || fifo_empty[grant] sampled in the capture cycle. The empty flag then reflects all reads up to and including this one.
  - Increment beat_cnt.
  - If last=1, no further reads issue and the state goes to DONE.
- Simultaneous capture and issue: if fifo_empty[grant]=0 in the capture cycle, issue proceeds in the same cycle.
- A producer writing to the granted FIFO mid-packet extends the packet up to BURST beats.
- State DONE (1 cycle): last_grant <= grant; go to IDLE.
  - Re-arbitration does not wait for the output buffer to drain. Beats carry their own tdest/tlast.
- Packets never interleave; tdest is constant within a packet.
- Minimum packet is 1 beat: the FIFO holds 1 word, and tlast is set on that beat.
- Wrap-around: last_grant=N-1 searches from index 0.

Optional Feature:
- AXIS_ARB_FIXED_PRIO_EN defined: arbitration in IDLE picks the lowest-index non-empty FIFO; last_grant is ignored, and a continuously non-empty FIFO 0 may starve the others.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then FIFO0 preloaded with 3 words 0xA0..0xA2, tready=1 -> 3 beats 0xA0,0xA1,0xA2 with tdest=0, tlast only on 0xA2, and fifo_rd_en[0] high for exactly 3 cycles.
- FIFO1 holds 20 words, BURST=8 -> packets of 8, 8, 4 with tlast on beats 8, 16 and 20. All tdest=1, data in order.
- FIFOs 0, 2 and 3 each hold 2 words -> packet order tdest 0, 2, 3, each of 2 beats. After a refill of FIFOs 0 and 3 with last_grant=3, the next grant is 0.
- tready toggled 1,0,0,1 repeatedly during a 8-beat packet -> no lost or duplicated beats, outputs stable while stalled, occupancy never >2.
- rst asserted for 1 cycle at beat 4 of an 8-beat packet -> next cycle tvalid=0 and fifo_rd_en=0. After reset, arbitration restarts at FIFO 0 and no stray tlast appears.
- AXIS_ARB_FIXED_PRIO_EN with FIFOs 0 and 1 both non-empty -> FIFO 0 is granted repeatedly until empty; FIFO 1 is served only after that.
